dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 8-byte data memory responder with fixed response latency
// Optional DMEM_ALIGN_CHECK_EN: flags addresses that are not 8-byte aligned as errors.
module dmem_responder #(
    parameter int MEM_BYTES = 2048,
    parameter int LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_error_o,
    output logic        busy_o
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [7:0]  mem [MEM_BYTES];

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic        acc_err;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic [63:0] rd_bytes;
    logic [AW-1:0] idx;

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign accept      = req_valid_i && (state == IDLE);
    assign enter_resp  = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);

    // With LATENCY=1 the access happens on the accepting edge, so use the live request.
    assign acc_we    = (state == IDLE) ? req_we_i    : lat_we;
    assign acc_addr  = (state == IDLE) ? req_addr_i  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;
    assign idx       = acc_addr[AW-1:0];

    always_comb begin
        acc_err = acc_addr > 64'(MEM_BYTES - 8);
`ifdef DMEM_ALIGN_CHECK_EN
        if (acc_addr[2:0] != 3'd0) acc_err = 1'b1;
`endif
    end

    always_comb begin
        rd_bytes = '0;
        for (int k = 0; k < 8; k++) begin
            rd_bytes[8*k +: 8] = mem[idx + AW'(k)];
        end
    end

    // Memory is deliberately outside reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && acc_we && !acc_err) begin
            for (int k = 0; k < 8; k++) begin
                mem[idx + AW'(k)] <= acc_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_we      <= 1'b0;
            lat_addr    <= 64'd0;
            lat_wdata   <= 64'd0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 64'd0;
            rsp_error_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we_i;
                        lat_addr  <= req_addr_i;
                        lat_wdata <= req_wdata_i;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_valid_o <= 1'b1;
                rsp_error_o <= acc_err;
                rsp_rdata_o <= (acc_we || acc_err) ? 64'd0 : rd_bytes;
            end else if (state == RESP && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_error_o <= 1'b0;
                rsp_rdata_o <= 64'd0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a byte-array model
module tb_dmem_responder;
    localparam int MEM_BYTES = 2048;
    localparam int LAT       = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [63:0] req_addr_i = 64'd0;
    logic [63:0] req_wdata_i = 64'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [63:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        busy_o;

    dmem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        longint      acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  model_mem [MEM_BYTES];
    longint      cyc = 0;
    longint      last_acc = -1;
    longint      rise_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rdy_mode = 1'b0;
    bit          prev_valid = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic model(input logic we, input logic [63:0] a, input logic [63:0] wd, output exp_t e);
        e.rdata = 64'd0;
        e.acc   = 0;
        e.err   = (a > 64'(MEM_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[2:0] != 3'd0) e.err = 1'b1;
`endif
        if (!e.err) begin
            for (int k = 0; k < 8; k++) begin
                if (we) model_mem[int'(a[10:0]) + k] = wd[8*k +: 8];
                else    e.rdata[8*k +: 8] = model_mem[int'(a[10:0]) + k];
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with req_valid_i still high.
    task automatic do_req(input logic we, input logic [63:0] a, input logic [63:0] wd, input bit chk_gap);
        exp_t e;
        int   n;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = wd;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready_o stayed 0 for %0d cycles", n);
            req_valid_i = 1'b0;
            return;
        end
        model(we, a, wd, e);
        e.acc = cyc + 1;
        if (chk_gap && last_acc >= 0) chk("accept_gap", 64'(e.acc - last_acc), 64'(LAT + 1));
        last_acc = e.acc;
        q.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_req();
        req_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
        chk({tag, "_rsp_error"}, 64'(rsp_error_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", q.size());
            q.delete();
        end
    endtask

    // Monitor: every cycle a response is shown it must match the queue head; pop on handshake.
    always begin
        @(negedge clk_i);
        #1;
        if (rst_i) begin
            prev_valid = 1'b0;
        end else if (rsp_valid_o) begin
            if (!prev_valid) rise_cyc = cyc;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rdata=0x%016h err=%0b with nothing outstanding",
                         rsp_rdata_o, rsp_error_o);
            end else begin
                chk("rsp_rdata", rsp_rdata_o, q[0].rdata);
                chk("rsp_error", 64'(rsp_error_o), 64'(q[0].err));
                chk("req_ready_in_resp", 64'(req_ready_o), 64'd0);
                chk("busy_in_resp", 64'(busy_o), 64'd1);
                if (rsp_ready_i) begin
                    chk("rsp_latency", 64'(rise_cyc - q[0].acc), 64'(LAT - 1));
                    void'(q.pop_front());
                end
            end
            prev_valid = rsp_valid_o && !rsp_ready_i;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (rdy_mode) rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Zero the whole memory so every later expectation is fully defined.
        for (int i = 0; i < MEM_BYTES; i += 8) do_req(1'b1, 64'(i), 64'd0, 1'b0);
        idle_req();
        drain();

        do_req(1'b1, 64'h100, 64'h1122334455667788, 1'b0);
        do_req(1'b0, 64'h100, 64'd0, 1'b0);
        do_req(1'b0, 64'h7F8, 64'd0, 1'b0);
        do_req(1'b0, 64'h7F9, 64'd0, 1'b0);
        do_req(1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEFCAFEF00D, 1'b0);
        do_req(1'b0, 64'h0, 64'd0, 1'b0);
        do_req(1'b0, 64'h7F8, 64'd0, 1'b0);
        do_req(1'b0, 64'h103, 64'd0, 1'b0);
        idle_req();
        drain();

        // Stall in RESP with a stray request pulse that must be ignored.
        rsp_ready_i = 1'b0;
        do_req(1'b0, 64'h100, 64'd0, 1'b0);
        idle_req();
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 64'h200;
        req_wdata_i = 64'h5A5A5A5A5A5A5A5A;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rsp_ready_i = 1'b1;
        drain();
        do_req(1'b0, 64'h200, 64'd0, 1'b0);
        idle_req();
        drain();

        // Reset while a write sits in WAIT.
        do_req(1'b1, 64'h40, 64'h0123456789ABCDEF, 1'b0);
        idle_req();
        drain();
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 64'h40;
        req_wdata_i = 64'hAAAAAAAAAAAAAAAA;
        while (!req_ready_o) @(negedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("mid_reset");
        rst_i = 1'b0;
        do_req(1'b0, 64'h40, 64'd0, 1'b0);
        idle_req();
        drain();

        // Back-to-back requests with ready held high.
        last_acc = -1;
        for (int i = 0; i < 6; i++) do_req(i[0], 64'(8 * i), {$urandom, $urandom}, 1'b1);
        idle_req();
        drain();

        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a;
            case ($urandom_range(0, 5))
                0:       a = 64'($urandom_range(0, MEM_BYTES - 8));
                1:       a = 64'(8 * $urandom_range(0, MEM_BYTES / 8 - 1));
                2:       a = 64'(MEM_BYTES - 8 + $urandom_range(0, 15));
                3:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 255));
            endcase
            do_req($urandom_range(0, 1) == 1, a, {$urandom, $urandom}, 1'b0);
            repeat ($urandom_range(0, 2)) idle_req();
        end
        idle_req();
        rdy_mode = 1'b0;
        @(posedge clk_i);
        #2;
        rsp_ready_i = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
